// File: rtl/fmap_pingpong_buffer.sv
// Ping-pong feature-map buffer: one bank captures a full frame while the other replays
// its frame in raster order under ready/valid backpressure.
module fmap_pingpong_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int CH         = 8,
    parameter int FRAME_W    = 112,
    parameter int FRAME_H    = 112
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CH*DATA_WIDTH-1:0] i_data,
    input  logic                     valid_in,
    output logic                     in_ready,
    output logic [CH*DATA_WIDTH-1:0] o_data,
    output logic                     valid_out,
    input  logic                     out_ready,
    output logic                     o_last,
    output logic                     frame_done,
    output logic                     overflow
);
    localparam int WORD_W = CH * DATA_WIDTH;
    localparam int DEPTH  = FRAME_W * FRAME_H;
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    logic [WORD_W-1:0] mem0 [0:DEPTH-1];
    logic [WORD_W-1:0] mem1 [0:DEPTH-1];

    bank_state_e bank_q [2];
    bank_state_e bank_d [2];
    logic          wr_bank_q, wr_bank_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic          iss_bank_q, iss_bank_d;
    logic [AW-1:0] iss_addr_q, iss_addr_d;
    logic          rd_bank_q, rd_bank_d;
    logic [WORD_W-1:0] o_data_q;
    logic          valid_out_q, valid_out_d;
    logic          o_last_q, o_last_d;
    logic          frame_done_q;
    logic          overflow_q, overflow_d;

    logic in_ready_s, wr_en_s, wr_last_s;
    logic can_issue_s, slot_free_s, rd_en_s, rd_last_s, hs_last_s;

    // Handshake decode. iss_* walks the read pointer ahead of the output register,
    // so the next bank's word 0 can be fetched in the same cycle the last word leaves.
    always_comb begin
        in_ready_s  = (bank_q[wr_bank_q] == BANK_EMPTY) || (bank_q[wr_bank_q] == BANK_FILLING);
        wr_en_s     = valid_in && in_ready_s;
        wr_last_s   = wr_en_s && (wr_addr_q == LAST_ADDR);
        can_issue_s = (bank_q[iss_bank_q] == BANK_FULL) || (bank_q[iss_bank_q] == BANK_DRAINING);
        slot_free_s = !valid_out_q || out_ready;
        rd_en_s     = can_issue_s && slot_free_s;
        rd_last_s   = rd_en_s && (iss_addr_q == LAST_ADDR);
        hs_last_s   = valid_out_q && out_ready && o_last_q;
    end

    // Per-bank lifecycle: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bank_d[b] = bank_q[b];
            case (bank_q[b])
                BANK_EMPTY, BANK_FILLING: begin
                    if (wr_en_s && (wr_bank_q == 1'(b))) begin
                        bank_d[b] = wr_last_s ? BANK_FULL : BANK_FILLING;
                    end else begin
                        bank_d[b] = bank_q[b];
                    end
                end
                BANK_FULL: begin
                    if (rd_en_s && (iss_bank_q == 1'(b))) begin
                        bank_d[b] = BANK_DRAINING;
                    end else begin
                        bank_d[b] = bank_q[b];
                    end
                end
                BANK_DRAINING: begin
                    if (hs_last_s && (rd_bank_q == 1'(b))) begin
                        bank_d[b] = BANK_EMPTY;
                    end else begin
                        bank_d[b] = bank_q[b];
                    end
                end
                default: bank_d[b] = BANK_EMPTY;
            endcase
        end
    end

    // Pointer, output-control and flag next-state.
    always_comb begin
        wr_addr_d   = wr_addr_q;
        wr_bank_d   = wr_bank_q;
        iss_addr_d  = iss_addr_q;
        iss_bank_d  = iss_bank_q;
        rd_bank_d   = rd_bank_q;
        valid_out_d = valid_out_q;
        o_last_d    = o_last_q;
        overflow_d  = overflow_q | (valid_in & ~in_ready_s);
        if (wr_en_s) begin
            wr_addr_d = wr_last_s ? {AW{1'b0}} : (wr_addr_q + AW'(1));
            wr_bank_d = wr_last_s ? ~wr_bank_q : wr_bank_q;
        end else begin
            wr_addr_d = wr_addr_q;
        end
        if (rd_en_s) begin
            iss_addr_d  = rd_last_s ? {AW{1'b0}} : (iss_addr_q + AW'(1));
            iss_bank_d  = rd_last_s ? ~iss_bank_q : iss_bank_q;
            valid_out_d = 1'b1;
            o_last_d    = (iss_addr_q == LAST_ADDR);
        end else if (out_ready) begin
            valid_out_d = 1'b0;
            o_last_d    = 1'b0;
        end else begin
            valid_out_d = valid_out_q;
        end
        if (hs_last_s) begin
            rd_bank_d = ~rd_bank_q;
        end else begin
            rd_bank_d = rd_bank_q;
        end
    end

    // Frame storage; contents survive reset and are only reachable through FULL banks.
    always_ff @(posedge clk) begin
        if (wr_en_s && !wr_bank_q) begin
            mem0[wr_addr_q] <= i_data;
        end
        if (wr_en_s && wr_bank_q) begin
            mem1[wr_addr_q] <= i_data;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0]    <= BANK_EMPTY;
            bank_q[1]    <= BANK_EMPTY;
            wr_bank_q    <= 1'b0;
            wr_addr_q    <= {AW{1'b0}};
            iss_bank_q   <= 1'b0;
            iss_addr_q   <= {AW{1'b0}};
            rd_bank_q    <= 1'b0;
            o_data_q     <= {WORD_W{1'b0}};
            valid_out_q  <= 1'b0;
            o_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            bank_q[0]    <= bank_d[0];
            bank_q[1]    <= bank_d[1];
            wr_bank_q    <= wr_bank_d;
            wr_addr_q    <= wr_addr_d;
            iss_bank_q   <= iss_bank_d;
            iss_addr_q   <= iss_addr_d;
            rd_bank_q    <= rd_bank_d;
            valid_out_q  <= valid_out_d;
            o_last_q     <= o_last_d;
            frame_done_q <= hs_last_s;
            overflow_q   <= overflow_d;
            if (rd_en_s) begin
                o_data_q <= iss_bank_q ? mem1[iss_addr_q] : mem0[iss_addr_q];
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign o_data     = o_data_q;
    assign valid_out  = valid_out_q;
    assign o_last     = o_last_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
endmodule
